sobel_image_receiver: RTL and testbench

//  Front end of the Sobel pipeline: latches the 64-bit image header, computes image size and walks a
//  3x3 window over a byte-per-pixel, row-major grayscale image in external memory. Each accepted
//  24-bit column (3 vertically adjacent pixels) is shifted into a 72-bit window for the Sobel core.

---
 rtl/image_receiver_pkg.sv | 22 ++
 rtl/window_shift_reg.sv | 41 ++++
 rtl/sobel_image_receiver.sv | 123 ++++++++++++
 tb/tb_sobel_image_receiver.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_receiver_pkg.sv
// Shared widths, FSM state type and header helpers for the Sobel image receiver.
package image_receiver_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned COL_W   = 3 * PIX_W;
  localparam int unsigned WIN_W   = 3 * COL_W;
  localparam int unsigned HDR_W   = 64;
  localparam int unsigned RADDR_W = 32;
  localparam int unsigned WADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } rx_state_e;

  // A 3x3 window needs at least three rows and three columns.
  function automatic logic header_too_small(input logic [HDR_W-1:0] hdr);
    return (hdr[63:32] < 32'd3) || (hdr[31:0] < 32'd3);
  endfunction

endpackage

// File: rtl/window_shift_reg.sv
// Three-column shift register forming the 3x3 window, with fill count and full flag.
module window_shift_reg
  import image_receiver_pkg::*;
#(
  parameter int unsigned CW = COL_W
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic          shift_en,
  input  logic          band_wrap,
  input  logic [CW-1:0] col_in,
  output logic [3*CW-1:0] window,
  output logic          buffer_full,
  output logic          window_done
);

  logic [1:0] count_q;
  logic [1:0] count_inc;

  assign count_inc   = (count_q == 2'd3) ? 2'd3 : count_q + 2'd1;
  assign window_done = shift_en && (count_inc == 2'd3);

  // On a band wrap the count restarts but the flag keeps describing the window
  // just formed; it falls once the first column of the new band arrives.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      window      <= '0;
      count_q     <= '0;
      buffer_full <= 1'b0;
    end else if (clear) begin
      count_q     <= '0;
      buffer_full <= 1'b0;
    end else if (shift_en) begin
      window      <= {window[2*CW-1:0], col_in};
      count_q     <= band_wrap ? 2'd0 : count_inc;
      buffer_full <= (count_inc == 2'd3);
    end
  end

endmodule

// File: rtl/sobel_image_receiver.sv
// Header latch, scan FSM and address generation feeding 3x3 windows to the Sobel core.
module sobel_image_receiver
  import image_receiver_pkg::*;
#(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned RADDR_W = 32,
  parameter int unsigned WADDR_W = 17
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [3*PIX_W-1:0]   pixel_data,
  input  logic [63:0]          header_data_in,
  input  logic                 read_buffer,
  input  logic                 read_header,
  input  logic [15:0]          default_address,
  output logic                 buffer_full,
  output logic [63:0]          header_data_out,
  output logic [9*PIX_W-1:0]   image_buffer,
  output logic [WADDR_W-1:0]   w_address,
  output logic [RADDR_W-1:0]   r_address,
  output logic                 new_col,
  output logic                 image_complete,
  output logic [RADDR_W-1:0]   image_size
);

  rx_state_e state_q, state_d;

  logic [RADDR_W-1:0] img_w, img_h;
  logic [RADDR_W-1:0] row_q, col_q, row_base_q;
  logic [RADDR_W-1:0] base_addr;
  logic               accept, last_col, last_row, last_window;
  logic               hdr_small, window_done, seen_window_q;

  assign img_w       = RADDR_W'(header_data_out[63:32]);
  assign img_h       = RADDR_W'(header_data_out[31:0]);
  assign base_addr   = RADDR_W'(default_address);
  assign hdr_small   = header_too_small(header_data_in);
  assign accept      = read_buffer && !read_header && (state_q == SCAN);
  assign last_col    = (col_q == img_w - RADDR_W'(1));
  assign last_row    = (row_q == img_h - RADDR_W'(3));
  assign last_window = last_col && last_row;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (read_header) begin
      state_d = hdr_small ? DONE : SCAN;
    end else if (accept && last_window) begin
      state_d = DONE;
    end
  end

  window_shift_reg #(
    .CW(3 * PIX_W)
  ) u_window (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (read_header),
    .shift_en   (accept),
    .band_wrap  (accept && last_col),
    .col_in     (pixel_data),
    .window     (image_buffer),
    .buffer_full(buffer_full),
    .window_done(window_done)
  );

  // row_base_q tracks r*W incrementally so no second multiplier is needed.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      header_data_out <= '0;
      image_size      <= '0;
      row_q           <= '0;
      col_q           <= '0;
      row_base_q      <= '0;
      r_address       <= '0;
      w_address       <= '0;
      seen_window_q   <= 1'b0;
      new_col         <= 1'b0;
      image_complete  <= 1'b0;
    end else if (read_header) begin
      header_data_out <= header_data_in;
      image_size      <= RADDR_W'(header_data_in[63:32] * header_data_in[31:0]);
      row_q           <= '0;
      col_q           <= '0;
      row_base_q      <= '0;
      r_address       <= base_addr;
      w_address       <= '0;
      seen_window_q   <= 1'b0;
      new_col         <= 1'b0;
      image_complete  <= hdr_small;
    end else if (accept) begin
      new_col <= 1'b1;
      if (last_col) begin
        col_q      <= '0;
        row_q      <= row_q + RADDR_W'(1);
        row_base_q <= row_base_q + img_w;
        r_address  <= base_addr + row_base_q + img_w;
      end else begin
        col_q     <= col_q + RADDR_W'(1);
        r_address <= base_addr + row_base_q + col_q + RADDR_W'(1);
      end
      if (window_done) begin
        seen_window_q <= 1'b1;
        if (seen_window_q) begin
          w_address <= w_address + WADDR_W'(1);
        end
      end
      if (last_window) begin
        image_complete <= 1'b1;
      end
    end else begin
      new_col <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_image_receiver.sv
// Randomized self-checking bench for sobel_image_receiver against a window/address model.
module tb_sobel_image_receiver;

  logic        tb_clk = 1'b0;
  logic        n_rst;
  logic [23:0] pixel_data;
  logic [63:0] header_data_in;
  logic        read_buffer;
  logic        read_header;
  logic [15:0] default_address;
  logic        buffer_full;
  logic [63:0] header_data_out;
  logic [71:0] image_buffer;
  logic [16:0] w_address;
  logic [31:0] r_address;
  logic        new_col;
  logic        image_complete;
  logic [31:0] image_size;

  always #5 tb_clk = ~tb_clk;

  sobel_image_receiver #(
    .PIX_W  (8),
    .RADDR_W(32),
    .WADDR_W(17)
  ) dut (
    .clk            (tb_clk),
    .n_rst          (n_rst),
    .pixel_data     (pixel_data),
    .header_data_in (header_data_in),
    .read_buffer    (read_buffer),
    .read_header    (read_header),
    .default_address(default_address),
    .buffer_full    (buffer_full),
    .header_data_out(header_data_out),
    .image_buffer   (image_buffer),
    .w_address      (w_address),
    .r_address      (r_address),
    .new_col        (new_col),
    .image_complete (image_complete),
    .image_size     (image_size)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: image geometry, position, and expected outputs.
  int unsigned m_w, m_h, m_r, m_c, m_band, m_def;
  bit          m_scan, m_full, m_newcol, m_complete;
  logic [63:0] m_hdr;
  logic [31:0] m_size, m_ra;
  logic [71:0] m_buf;
  logic [16:0] m_wa;

  function automatic void model_reset();
    m_w = 0; m_h = 0; m_r = 0; m_c = 0; m_band = 0;
    m_scan = 0; m_full = 0; m_newcol = 0; m_complete = 0;
    m_hdr = '0; m_size = '0; m_ra = '0; m_buf = '0; m_wa = '0;
  endfunction

  function automatic void model_header(input logic [63:0] hdr);
    logic [31:0] wv, hv;
    wv = hdr[63:32];
    hv = hdr[31:0];
    m_hdr = hdr;
    m_size = wv * hv;
    m_w = wv; m_h = hv;
    m_r = 0; m_c = 0; m_band = 0;
    m_full = 0; m_newcol = 0; m_wa = '0;
    m_ra = 32'(m_def);
    m_complete = (m_w < 3) || (m_h < 3);
    m_scan = !m_complete;
  endfunction

  function automatic void model_accept(input logic [23:0] col);
    m_newcol = m_scan;
    if (!m_scan) return;
    m_buf = {m_buf[47:0], col};
    m_band++;
    m_full = (m_band >= 3);
    if (m_full) m_wa = 17'(m_r * (m_w - 2) + (m_c - 2));
    if (m_c == m_w - 1) begin
      if (m_r == m_h - 3) begin
        m_complete = 1;
        m_scan = 0;
      end
      m_c = 0;
      m_r++;
      m_band = 0;
    end else begin
      m_c++;
    end
    m_ra = 32'(m_def + m_r * m_w + m_c);
  endfunction

  task automatic cycle();
    @(posedge tb_clk);
    @(negedge tb_clk);
  endtask

  task automatic apply_col(input logic [23:0] col);
    read_buffer = 1'b1;
    pixel_data  = col;
    cycle();
    read_buffer = 1'b0;
    model_accept(col);
  endtask

  task automatic apply_idle();
    cycle();
    m_newcol = 0;
  endtask

  task automatic apply_header(input logic [63:0] hdr);
    header_data_in = hdr;
    read_header    = 1'b1;
    cycle();
    read_header    = 1'b0;
    model_header(hdr);
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    cycle();
    cycle();
    n_rst = 1'b0;
    model_reset();
    n_vec++;
    if ({buffer_full, new_col, image_complete} !== 3'b000 || header_data_out !== '0 ||
        image_buffer !== '0 || w_address !== '0 || r_address !== '0 || image_size !== '0) begin
      n_err++;
      $display("FAIL reset: full=%b new=%b cmp=%b hdr=%h buf=%h wa=%0d ra=%h size=%h, required all 0",
               buffer_full, new_col, image_complete, header_data_out, image_buffer,
               w_address, r_address, image_size);
    end
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 3; i++) begin
      apply_col(24'($urandom));
      n_vec++;
      if (new_col !== 1'b0 || image_buffer !== '0 || r_address !== '0 || buffer_full !== 1'b0) begin
        n_err++;
        $display("FAIL idle_ignore: new=%b buf=%h ra=%h full=%b, required 0", new_col,
                 image_buffer, r_address, buffer_full);
      end
    end
  endtask

  task automatic test_header();
    m_def = 0;
    default_address = 16'h0000;
    apply_header(64'h0000003000000030);
    n_vec++;
    if (header_data_out !== 64'h0000003000000030 || image_size !== 32'h900 ||
        r_address !== 32'h0 || image_complete !== 1'b0 || new_col !== 1'b0) begin
      n_err++;
      $display("FAIL header: hdr=%h size=%h ra=%h cmp=%b new=%b, required hdr=%h size=900 ra=0 cmp=0 new=0",
               header_data_out, image_size, r_address, image_complete, new_col, 64'h0000003000000030);
    end
  endtask

  task automatic test_first_window();
    for (int i = 0; i < 3; i++) begin
      apply_col(24'h232323);
      n_vec++;
      if (new_col !== 1'b1 || buffer_full !== (i == 2)) begin
        n_err++;
        $display("FAIL first_window_col%0d: new=%b full=%b, required new=1 full=%b", i, new_col,
                 buffer_full, (i == 2));
      end
    end
    n_vec++;
    if (image_buffer !== 72'h232323232323232323 || w_address !== 17'd0 || r_address !== 32'd3) begin
      n_err++;
      $display("FAIL first_window: buf=%h wa=%0d ra=%0d, required buf=232323232323232323 wa=0 ra=3",
               image_buffer, w_address, r_address);
    end
    apply_col(24'($urandom));
    n_vec++;
    if (w_address !== 17'd1 || r_address !== 32'd4 || buffer_full !== 1'b1) begin
      n_err++;
      $display("FAIL second_window: wa=%0d ra=%0d full=%b, required wa=1 ra=4 full=1", w_address,
               r_address, buffer_full);
    end
    apply_idle();
    n_vec++;
    if (new_col !== 1'b0) begin
      n_err++;
      $display("FAIL new_col_pulse: new=%b, required 0", new_col);
    end
  endtask

  task automatic test_band_wrap();
    m_def = 32'h100;
    default_address = 16'h0100;
    apply_header(64'h0000003000000030);
    for (int i = 0; i < 48; i++) apply_col(24'($urandom));
    n_vec++;
    if (r_address !== 32'h130 || buffer_full !== 1'b1 || w_address !== 17'd45 || image_buffer !== m_buf) begin
      n_err++;
      $display("FAIL band_wrap: ra=%h full=%b wa=%0d buf=%h, required ra=130 full=1 wa=45 buf=%h",
               r_address, buffer_full, w_address, image_buffer, m_buf);
    end
    apply_col(24'($urandom));
    n_vec++;
    if (buffer_full !== 1'b0 || r_address !== 32'h131 || w_address !== 17'd45) begin
      n_err++;
      $display("FAIL band_wrap_next: full=%b ra=%h wa=%0d, required full=0 ra=131 wa=45",
               buffer_full, r_address, w_address);
    end
  endtask

  // Scans an entire image with random gaps, comparing every cycle to the model.
  task automatic scan_image(input string name, input logic [31:0] wv, input logic [31:0] hv);
    int unsigned cols;
    m_def = $urandom_range(0, 65535);
    default_address = 16'(m_def);
    apply_header({wv, hv});
    cols = 0;
    while (m_scan && cols < 20000) begin
      if ($urandom_range(0, 3) == 0) apply_idle();
      else begin
        apply_col(24'($urandom));
        cols++;
      end
      n_vec++;
      if (new_col !== m_newcol || buffer_full !== m_full || image_complete !== m_complete ||
          image_buffer !== m_buf || w_address !== m_wa || r_address !== m_ra) begin
        n_err++;
        $display("FAIL %s col%0d: new=%b full=%b cmp=%b buf=%h wa=%0d ra=%h, required new=%b full=%b cmp=%b buf=%h wa=%0d ra=%h",
                 name, cols, new_col, buffer_full, image_complete, image_buffer, w_address,
                 r_address, m_newcol, m_full, m_complete, m_buf, m_wa, m_ra);
      end
    end
    n_vec++;
    if (cols !== (wv * (hv - 2)) || image_complete !== 1'b1 || image_size !== wv * hv) begin
      n_err++;
      $display("FAIL %s_end: cols=%0d cmp=%b size=%0d, required cols=%0d cmp=1 size=%0d", name,
               cols, image_complete, image_size, wv * (hv - 2), wv * hv);
    end
  endtask

  task automatic test_full_scan();
    scan_image("full_scan", 32'd48, 32'd48);
    n_vec++;
    if (w_address !== 17'd2115) begin
      n_err++;
      $display("FAIL full_scan_waddr: wa=%0d, required 2115", w_address);
    end
    for (int i = 0; i < 4; i++) begin
      apply_col(24'($urandom));
      n_vec++;
      if (new_col !== 1'b0 || image_buffer !== m_buf || w_address !== 17'd2115 ||
          r_address !== m_ra || image_complete !== 1'b1) begin
        n_err++;
        $display("FAIL done_ignore: new=%b buf=%h wa=%0d ra=%h cmp=%b, required new=0 buf=%h wa=2115 ra=%h cmp=1",
                 new_col, image_buffer, w_address, r_address, image_complete, m_buf, m_ra);
      end
    end
  endtask

  task automatic test_random_images();
    for (int k = 0; k < 6; k++) begin
      scan_image("rand_image", 32'($urandom_range(3, 9)), 32'($urandom_range(3, 9)));
    end
  endtask

  task automatic test_mid_reset();
    m_def = 16'h0040;
    default_address = 16'h0040;
    apply_header(64'h0000000A0000000A);
    for (int i = 0; i < 13; i++) apply_col(24'($urandom));
    n_rst = 1'b1;
    read_buffer = 1'b1;
    pixel_data = 24'($urandom);
    cycle();
    n_rst = 1'b0;
    read_buffer = 1'b0;
    model_reset();
    n_vec++;
    if ({buffer_full, new_col, image_complete} !== 3'b000 || header_data_out !== '0 ||
        image_buffer !== '0 || w_address !== '0 || r_address !== '0 || image_size !== '0) begin
      n_err++;
      $display("FAIL mid_reset: full=%b new=%b cmp=%b hdr=%h buf=%h wa=%0d ra=%h size=%h, required all 0",
               buffer_full, new_col, image_complete, header_data_out, image_buffer,
               w_address, r_address, image_size);
    end
    apply_col(24'($urandom));
    n_vec++;
    if (new_col !== 1'b0 || image_buffer !== '0) begin
      n_err++;
      $display("FAIL mid_reset_idle: new=%b buf=%h, required 0", new_col, image_buffer);
    end
  endtask

  task automatic test_header_priority();
    m_def = 16'h0200;
    default_address = 16'h0200;
    apply_header(64'h0000000800000006);
    for (int i = 0; i < 11; i++) apply_col(24'($urandom));
    read_buffer = 1'b1;
    pixel_data = 24'($urandom);
    header_data_in = 64'h0000000500000004;
    read_header = 1'b1;
    cycle();
    read_header = 1'b0;
    read_buffer = 1'b0;
    model_header(64'h0000000500000004);
    n_vec++;
    if (header_data_out !== 64'h0000000500000004 || image_size !== 32'd20 || new_col !== 1'b0 ||
        r_address !== 32'h200 || w_address !== 17'd0 || buffer_full !== 1'b0 ||
        image_complete !== 1'b0 || image_buffer !== m_buf) begin
      n_err++;
      $display("FAIL header_priority: hdr=%h size=%0d new=%b ra=%h wa=%0d full=%b cmp=%b buf=%h, required size=20 new=0 ra=200 wa=0 full=0 cmp=0 buf=%h",
               header_data_out, image_size, new_col, r_address, w_address, buffer_full,
               image_complete, image_buffer, m_buf);
    end
    apply_col(24'($urandom));
    n_vec++;
    if (new_col !== 1'b1 || r_address !== 32'h201 || image_buffer !== m_buf) begin
      n_err++;
      $display("FAIL header_restart: new=%b ra=%h buf=%h, required new=1 ra=201 buf=%h", new_col,
               r_address, image_buffer, m_buf);
    end
  endtask

  task automatic test_small_image();
    apply_header(64'h000000020000000A);
    n_vec++;
    if (image_complete !== 1'b1 || image_size !== 32'd20 || new_col !== 1'b0) begin
      n_err++;
      $display("FAIL small_w: cmp=%b size=%0d new=%b, required cmp=1 size=20 new=0",
               image_complete, image_size, new_col);
    end
    apply_col(24'($urandom));
    n_vec++;
    if (new_col !== 1'b0 || image_buffer !== m_buf || r_address !== m_ra) begin
      n_err++;
      $display("FAIL small_ignore: new=%b buf=%h ra=%h, required new=0 buf=%h ra=%h", new_col,
               image_buffer, r_address, m_buf, m_ra);
    end
    apply_header(64'h0000000900000002);
    n_vec++;
    if (image_complete !== 1'b1 || image_size !== 32'd18) begin
      n_err++;
      $display("FAIL small_h: cmp=%b size=%0d, required cmp=1 size=18", image_complete, image_size);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b1;
    pixel_data = '0;
    header_data_in = '0;
    read_buffer = 1'b0;
    read_header = 1'b0;
    default_address = '0;
    m_def = 0;
    model_reset();
    @(negedge tb_clk);
    test_reset();
    test_idle_ignore();
    test_header();
    test_first_window();
    test_band_wrap();
    test_full_scan();
    test_random_images();
    test_mid_reset();
    test_header_priority();
    test_small_image();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
